c1_conv_scheduler: RTL
======================

Name: c1_conv_scheduler

Overview:
- Sequences the C1 convolution stage for one 32x32 input frame, producing 28x28 outputs for each of 6 channels.
- Generates output-pixel coordinates and channel select for the conv PEs in channel-fastest, then column, then row order. This is the same order the downstream C1 register/ping-pong controller consumes.
- Regenerates the delayed conv_valid strobe, counts pooled 2x2 results returned downstream, and signals frame completion.
- Sits between the top-level layer controller and the conv PE array / register controller.

Parameters:
- OUT_W, 28, output columns per row
- OUT_H, 28, output rows per frame (must be even)
- N_CH, 6, output channels, serialised one per issue cycle
- PE_LAT, 3, cycles from issue to PE result valid (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  frame start request; accepted only in IDLE
- in_ready  in  1  input window data available; low stalls issue
- pool_valid  in  1  one 2x2 pooled beat returned from register controller
- issue_valid  out  1  PE issue strobe for current row/col/ch
- issue_row  out  5  output row 0..OUT_H-1
- issue_col  out  5  output column 0..OUT_W-1
- issue_ch  out  3  channel 0..N_CH-1
- conv_valid  out  1  issue_valid delayed exactly PE_LAT cycles
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse at frame completion
- pool_cnt  out  8  pooled beats received this frame

Behaviour:
- Reset values: all outputs 0, state IDLE, the PE_LAT-deep valid shift register cleared. Reset mid-frame aborts immediately; no done pulse is produced.
- Interface decision: one clock, clk; reset is synchronous and active-high.
- States are IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 -> RUN next cycle; row, col, ch and pool_cnt cleared to 0.
  - pool_valid is ignored.
- RUN:
  - issue_valid = in_ready, combinational from registered state.
  - Counters advance only on issue_valid:
    - ch = N_CH-1 wraps ch to 0 and increments col.
    - col = OUT_W-1 together with ch wrap wraps col to 0 and increments row.
  - in_ready low holds all coordinates, with issue_valid=0.
  - The issue with row=OUT_H-1, col=OUT_W-1, ch=N_CH-1 -> DRAIN next cycle; coordinates hold.
  - Total issues per frame = OUT_W*OUT_H*N_CH = 4704.
- conv_valid:
  - Shift register of issue_valid, depth PE_LAT.
  - Keeps shifting in every state except under reset.
- pool_cnt:
  - Increments on pool_valid in RUN or DRAIN.
  - Saturates at (OUT_W/2)*(OUT_H/2) = 196; further beats are ignored.
- DRAIN: exit to DONE when the shift register is empty AND pool_cnt == 196, including pool_valid arriving the same cycle that reaches 196.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - pool_cnt holds its final value until the next accepted start.
- start in RUN, DRAIN or DONE is ignored; it is not queued.
- start and reset asserted together: reset wins.
- Coordinate outputs are registered, valid whenever issue_valid=1, don't-care otherwise (they hold their last value).

Optional Feature:
- Macro C1_SEQ_PERF_EN.
- When defined:
  - Adds output port stall_cnt, 16 bits.
  - Counts cycles in RUN with in_ready=0, saturating at 0xFFFF.
  - Cleared by reset and on accepted start; holds after the frame.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Nominal frame: start pulse, in_ready=1 constant, model returns pool_valid 196 times after rows complete -> exactly 4704 issue_valid cycles. First issue is (0,0,0) one cycle after start; last is (27,27,5). conv_valid trails by 3 cycles; done pulses once; pool_cnt=196.
- Ordering: check the first 8 issues -> (0,0,0..5), (0,1,0), (0,1,1). Check the row wrap: (0,27,5) is followed by (1,0,0).
- Stall: drop in_ready for 10 cycles mid-row at (5,13,2) -> no issue_valid during the stall; coordinates hold (5,13,2); resume issuing (5,13,2) when in_ready returns. With C1_SEQ_PERF_EN, stall_cnt=10 at done.
- Drain wait: all issues complete but only 195 pool_valid returned -> stays in DRAIN with busy=1 and no done. The 196th beat gives done on the following cycle.
- Reset mid-frame at issue (10,4,3) -> next cycle all outputs 0, state IDLE, conv_valid pipeline cleared. A new start gives a full 4704-issue frame.
- Ignored inputs: start pulses in RUN and pool_valid in IDLE -> no restart and pool_cnt stays 0. A 197th pool_valid in DRAIN leaves pool_cnt=196.

Source files
------------

// File: rtl/c1_conv_scheduler.sv
// c1_conv_scheduler: sequences the C1 convolution stage for one frame.
// Issues output-pixel coordinates to the conv PEs in channel-fastest, then
// column, then row order. Regenerates the delayed conv_valid strobe, counts
// pooled 2x2 beats returned by the register controller, and pulses done
// once the frame has fully drained.
// Optional feature macro: C1_SEQ_PERF_EN adds the stall_cnt port, a
// saturating count of RUN cycles spent waiting on in_ready.
module c1_conv_scheduler #(
    parameter int OUT_W  = 28,
    parameter int OUT_H  = 28,
    parameter int N_CH   = 6,
    parameter int PE_LAT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_ready,
    input  logic        pool_valid,
    output logic        issue_valid,
    output logic [4:0]  issue_row,
    output logic [4:0]  issue_col,
    output logic [2:0]  issue_ch,
    output logic        conv_valid,
    output logic        busy,
    output logic        done,
    output logic [7:0]  pool_cnt
`ifdef C1_SEQ_PERF_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [4:0] ROW_LAST   = 5'(OUT_H - 1);
    localparam logic [4:0] COL_LAST   = 5'(OUT_W - 1);
    localparam logic [2:0] CH_LAST    = 3'(N_CH - 1);
    localparam logic [7:0] POOL_TOTAL = 8'((OUT_W / 2) * (OUT_H / 2));

    state_t              state_q, state_d;
    logic [4:0]          row_q, row_d;
    logic [4:0]          col_q, col_d;
    logic [2:0]          ch_q, ch_d;
    logic [7:0]          poolCnt_q, poolCnt_d;
    logic [PE_LAT-1:0]   vldSr_q, vldSr_d;
    logic                poolInc;
    logic                lastIssue;

    // Beats beyond a full frame's worth are dropped so the count saturates.
    assign poolInc   = pool_valid && (poolCnt_q != POOL_TOTAL);
    assign lastIssue = (row_q == ROW_LAST) && (col_q == COL_LAST) && (ch_q == CH_LAST);

    // Next-state, coordinate stepping, pool counting and status outputs.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        ch_d        = ch_q;
        poolCnt_d   = poolCnt_q;
        issue_valid = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    row_d     = 5'd0;
                    col_d     = 5'd0;
                    ch_d      = 3'd0;
                    poolCnt_d = 8'd0;
                end
            end
            S_RUN: begin
                busy        = 1'b1;
                issue_valid = in_ready;
                if (poolInc) begin
                    poolCnt_d = poolCnt_q + 8'd1;
                end
                if (in_ready) begin
                    if (lastIssue) begin
                        state_d = S_DRAIN;
                    end else if (ch_q != CH_LAST) begin
                        ch_d = ch_q + 3'd1;
                    end else begin
                        ch_d = 3'd0;
                        if (col_q != COL_LAST) begin
                            col_d = col_q + 5'd1;
                        end else begin
                            col_d = 5'd0;
                            row_d = row_q + 5'd1;
                        end
                    end
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (poolInc) begin
                    poolCnt_d = poolCnt_q + 8'd1;
                end
                if ((vldSr_q == '0) && (poolCnt_d == POOL_TOTAL)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Valid pipeline shifts every cycle so conv_valid trails issue_valid by PE_LAT.
    always_comb begin
        vldSr_d    = '0;
        vldSr_d[0] = issue_valid;
        for (int i = 1; i < PE_LAT; i++) begin
            vldSr_d[i] = vldSr_q[i-1];
        end
    end

    // State, coordinate, pool count and valid pipeline registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            row_q     <= 5'd0;
            col_q     <= 5'd0;
            ch_q      <= 3'd0;
            poolCnt_q <= 8'd0;
            vldSr_q   <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            ch_q      <= ch_d;
            poolCnt_q <= poolCnt_d;
            vldSr_q   <= vldSr_d;
        end
    end

    assign issue_row  = row_q;
    assign issue_col  = col_q;
    assign issue_ch   = ch_q;
    assign conv_valid = vldSr_q[PE_LAT-1];
    assign pool_cnt   = poolCnt_q;

`ifdef C1_SEQ_PERF_EN
    logic [15:0] stallCnt_q;

    // Saturating count of RUN cycles lost to in_ready, restarted per frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCnt_q <= 16'd0;
        end else if ((state_q == S_IDLE) && start) begin
            stallCnt_q <= 16'd0;
        end else if ((state_q == S_RUN) && !in_ready && (stallCnt_q != 16'hFFFF)) begin
            stallCnt_q <= stallCnt_q + 16'd1;
        end
    end

    assign stall_cnt = stallCnt_q;
`endif

endmodule
